// File: rtl/vset_encode.sv
// vset_encode: vsetvl-style configuration encoder.
// A request (sew, lmul, avl) is captured in IDLE, encoded in ENC, and the
// granted vector length is computed in CALC. The result is held in RESP until
// the consumer takes it. vtype_q / vl_q hold the persistent configuration.
// Optional feature: define VSET_AVL_KEEP_EN to add the avl_keep input, which
// reuses the current vl_q in place of avl.
module vset_encode #(
    parameter int unsigned VLEN = 256,
    parameter int unsigned VL_W = $clog2(2 * VLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [7:0]      sew_in,
    input  logic [4:0]      lmul_in,
    input  logic [31:0]     avl,
`ifdef VSET_AVL_KEEP_EN
    input  logic            avl_keep,
`endif
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [6:0]      vtype_out,
    output logic [VL_W-1:0] vl_out,
    output logic [6:0]      vtype_q,
    output logic [VL_W-1:0] vl_q
);

    // Wide enough to hold VLEN shifted left by the largest lmul encoding (4).
    localparam int unsigned SH_W = $clog2(VLEN) + 5;
    localparam logic [6:0]  VTYPE_ILL = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENC,
        S_CALC,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [7:0]      sew_r;
    logic [4:0]      lmul_r;
    logic [31:0]     avl_r;

    logic [2:0]      sew_enc_r;
    logic [2:0]      lmul_enc_r;
    logic            vill_r;

    logic [2:0]      sew_enc_c;
    logic [2:0]      lmul_enc_c;
    logic            vill_c;

    logic [SH_W-1:0] vlen_ext;
    logic [2:0]      sew_shift;
    logic [SH_W-1:0] vlmax_full;
    logic [VL_W-1:0] vlmax;
    logic [VL_W-1:0] vl_c;
    logic [6:0]      vtype_c;

    logic            accept;
    logic [31:0]     avl_src;

    assign accept = req_valid && (state == S_IDLE);

`ifdef VSET_AVL_KEEP_EN
    // Keeping vl routes the current vl_q through the same min() path as avl.
    assign avl_src = avl_keep ? 32'(vl_q) : avl;
`else
    assign avl_src = avl;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = S_ENC;
                end
            end
            S_ENC: begin
                state_nxt = S_CALC;
            end
            S_CALC: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sew_r  <= '0;
            lmul_r <= '0;
            avl_r  <= '0;
        end else if (accept) begin
            sew_r  <= sew_in;
            lmul_r <= lmul_in;
            avl_r  <= avl_src;
        end
    end

    // sew / lmul encoding; any unsupported value flags vill.
    always_comb begin
        sew_enc_c  = '0;
        lmul_enc_c = '0;
        vill_c     = 1'b0;
        case (sew_r)
            8'd8:    sew_enc_c = 3'b000;
            8'd16:   sew_enc_c = 3'b001;
            8'd32:   sew_enc_c = 3'b010;
            8'd64:   sew_enc_c = 3'b011;
            8'd128:  sew_enc_c = 3'b100;
            default: vill_c    = 1'b1;
        endcase
        case (lmul_r)
            5'd1:    lmul_enc_c = 3'b000;
            5'd2:    lmul_enc_c = 3'b001;
            5'd4:    lmul_enc_c = 3'b010;
            5'd8:    lmul_enc_c = 3'b011;
            5'd16:   lmul_enc_c = 3'b100;
            default: vill_c     = 1'b1;
        endcase
        if (vill_c) begin
            sew_enc_c  = '0;
            lmul_enc_c = '0;
        end
    end

    // Encoded fields are registered in ENC for use in CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sew_enc_r  <= '0;
            lmul_enc_r <= '0;
            vill_r     <= 1'b1;
        end else if (state == S_ENC) begin
            sew_enc_r  <= sew_enc_c;
            lmul_enc_r <= lmul_enc_c;
            vill_r     <= vill_c;
        end
    end

    // VLMAX by shifts and vl = min(avl, VLMAX) with a full 32-bit compare.
    always_comb begin
        vlen_ext   = SH_W'(VLEN);
        sew_shift  = sew_enc_r + 3'd3;
        vlmax_full = (vlen_ext << lmul_enc_r) >> sew_shift;
        vlmax      = vlmax_full[VL_W-1:0];
        vl_c       = vlmax;
        vtype_c    = {1'b0, sew_enc_r, lmul_enc_r};
        if (avl_r < 32'(vlmax)) begin
            vl_c = avl_r[VL_W-1:0];
        end
        if (vill_r) begin
            vl_c    = '0;
            vtype_c = VTYPE_ILL;
        end
    end

    // Result and persistent configuration update on the CALC->RESP edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vtype_out <= VTYPE_ILL;
            vl_out    <= '0;
            vtype_q   <= VTYPE_ILL;
            vl_q      <= '0;
        end else if (state == S_CALC) begin
            vtype_out <= vtype_c;
            vl_out    <= vl_c;
            vtype_q   <= vtype_c;
            vl_q      <= vl_c;
        end
    end

endmodule

// File: tb/tb_vset_encode.sv
// Testbench for vset_encode (VLEN = 256). Build with VSET_AVL_KEEP_EN defined
// to also exercise the avl_keep input.
module tb_vset_encode;

    localparam int unsigned VLEN = 256;
    localparam int unsigned VL_W = $clog2(2 * VLEN) + 1;

    typedef struct packed {
        logic [6:0]      vt;
        logic [VL_W-1:0] vl;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [7:0]      sew_in = '0;
    logic [4:0]      lmul_in = '0;
    logic [31:0]     avl = '0;
`ifdef VSET_AVL_KEEP_EN
    logic            avl_keep = 1'b0;
`endif
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [6:0]      vtype_out;
    logic [VL_W-1:0] vl_out;
    logic [6:0]      vtype_q;
    logic [VL_W-1:0] vl_q;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    vset_encode #(.VLEN(VLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .sew_in    (sew_in),
        .lmul_in   (lmul_in),
        .avl       (avl),
`ifdef VSET_AVL_KEEP_EN
        .avl_keep  (avl_keep),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .vtype_out (vtype_out),
        .vl_out    (vl_out),
        .vtype_q   (vtype_q),
        .vl_q      (vl_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is taken.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got vtype 0x%0h vl %0d expected no response", vtype_out, vl_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_vtype", 32'(vtype_out), 32'(mon_e.vt));
                check("rsp_vl", 32'(vl_out), 32'(mon_e.vl));
            end
        end
    end

    // One request/response transaction; called just after a rising edge.
    task automatic run_req(input logic [7:0] s, input logic [4:0] l, input logic [31:0] a,
                           input logic k, input logic [6:0] evt, input logic [VL_W-1:0] evl,
                           input int stall, input bit pulse);
        int n;
        exp_t e;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        sew_in  = s;
        lmul_in = l;
        avl     = a;
`ifdef VSET_AVL_KEEP_EN
        avl_keep = k;
`else
        if (k) $display("note: avl_keep ignored in this build");
`endif
        req_valid = 1'b1;
        e.vt = evt;
        e.vl = evl;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        sew_in    = 8'hFF;
        lmul_in   = 5'h1F;
        avl       = '1;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        check("rsp_valid_enc", 32'(rsp_valid), 32'd0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (pulse && n == 1) begin
                req_valid = 1'b1;
                sew_in    = 8'd8;
                lmul_in   = 5'd1;
                avl       = 32'd7;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        // Accept edge, ENC->CALC edge, CALC->RESP edge: rsp_valid is seen
        // two edges after the accepting edge.
        check("rsp_latency", 32'(n), 32'd2);
        for (int i = 0; i < stall; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_vtype", 32'(vtype_out), 32'(evt));
            check("hold_vl", 32'(vl_out), 32'(evl));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("back_idle", 32'(req_ready), 32'd1);
        check("vtype_q", 32'(vtype_q), 32'(evt));
        check("vl_q", 32'(vl_q), 32'(evl));
        @(posedge clk); #1;
        check("still_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_vtype_out", 32'(vtype_out), 32'h40);
        check("rst_vl_out", 32'(vl_out), 32'd0);
        check("rst_vtype_q", 32'(vtype_q), 32'h40);
        check("rst_vl_q", 32'(vl_q), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_req(8'd32, 5'd2, 32'd10, 1'b0, 7'b0010001, 10'd10, 0, 1'b0);
        run_req(8'd8, 5'd16, 32'd1000, 1'b0, 7'b0000100, 10'd512, 0, 1'b0);
        run_req(8'd24, 5'd4, 32'd50, 1'b0, 7'b1000000, 10'd0, 0, 1'b1);
        run_req(8'd16, 5'd8, 32'd100, 1'b0, 7'b0001011, 10'd100, 5, 1'b0);

        // Reset while a request sits in CALC.
        sew_in    = 8'd64;
        lmul_in   = 5'd1;
        avl       = 32'd5;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_vtype_out", 32'(vtype_out), 32'h40);
        check("midrst_vl_out", 32'(vl_out), 32'd0);
        check("midrst_vtype_q", 32'(vtype_q), 32'h40);
        check("midrst_vl_q", 32'(vl_q), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("postrst_vl_q", 32'(vl_q), 32'd0);

        run_req(8'd64, 5'd1, 32'd0, 1'b0, 7'b0011000, 10'd0, 0, 1'b0);
        run_req(8'd64, 5'd1, 32'h8000_0005, 1'b0, 7'b0011000, 10'd4, 0, 1'b0);
        run_req(8'd8, 5'd3, 32'd20, 1'b0, 7'b1000000, 10'd0, 0, 1'b0);
        run_req(8'd128, 5'd1, 32'd3, 1'b0, 7'b0100000, 10'd2, 0, 1'b0);
        run_req(8'd16, 5'd1, 32'd16, 1'b0, 7'b0001000, 10'd16, 0, 1'b0);

`ifdef VSET_AVL_KEEP_EN
        run_req(8'd32, 5'd2, 32'd10, 1'b0, 7'b0010001, 10'd10, 0, 1'b0);
        run_req(8'd128, 5'd1, 32'd1000, 1'b1, 7'b0100000, 10'd2, 0, 1'b0);
        run_req(8'd8, 5'd1, 32'd0, 1'b1, 7'b0000000, 10'd2, 0, 1'b0);
`endif

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
